// File: rtl/sseg_frame_capture.sv
// Seven-segment bus readback: filters the scanned SEG/AN lines and rebuilds 8 BCD digits.
// Optional SSEG_CAP_SYNC_EN adds a two-flop input synchronizer for asynchronous pins.
module sseg_frame_capture #(
   parameter int STABLE_CYC = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg_in,
   input  logic [7:0]  an_in,
   input  logic        err_clr,
   output logic [31:0] digits_out,
   output logic        frame_valid,
   output logic        bad_pattern
);

   typedef enum logic {S_SETTLE, S_HOLD} state_t;

   localparam logic [15:0] CNT_MAX = 16'(STABLE_CYC - 1);

   logic [14:0] s_bus;

`ifdef SSEG_CAP_SYNC_EN
   logic [14:0] sync1_q, sync1_d;
   logic [14:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = {an_in, seg_in};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign s_bus = sync2_q;
`else
   assign s_bus = {an_in, seg_in};
`endif

   state_t      state_q, state_d;
   logic [14:0] prev_q, prev_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  seen_q, seen_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] digits_q, digits_d;
   logic        valid_q, valid_d;
   logic        bad_q, bad_d;

   logic        changed;
   logic        capture;
   logic [7:0]  cap_an;
   logic [4:0]  dec;

   function automatic logic one_cold(input logic [7:0] a);
      logic [7:0] z;
      z = ~a;
      return (z != 8'h00) && ((z & (z - 8'd1)) == 8'h00);
   endfunction

   // returns {undecodable, bcd}
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = 5'h00;
         7'h79:   r = 5'h01;
         7'h24:   r = 5'h02;
         7'h30:   r = 5'h03;
         7'h19:   r = 5'h04;
         7'h12:   r = 5'h05;
         7'h02:   r = 5'h06;
         7'h78:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h10:   r = 5'h09;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   // Capture uses prev_q: it is the value that has been stable for STABLE_CYC cycles,
   // even if the bus changes on the very edge the count completes.
   always_comb begin
      prev_d   = s_bus;
      changed  = (s_bus != prev_q);
      cap_an   = prev_q[14:7];
      dec      = seg_decode(prev_q[6:0]);

      cnt_d = cnt_q;
      if (changed)
         cnt_d = 16'd0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 16'd1;

      capture = (state_q == S_SETTLE) && (cnt_q == CNT_MAX) && one_cold(cap_an);

      state_d = state_q;
      if (capture)
         state_d = S_HOLD;
      if (changed)
         state_d = S_SETTLE;

      shadow_d = shadow_q;
      seen_d   = seen_q;
      digits_d = digits_q;
      valid_d  = 1'b0;

      if (seen_q == 8'hFF) begin
         digits_d = shadow_q;
         valid_d  = 1'b1;
         seen_d   = 8'h00;
      end

      if (capture) begin
         for (int i = 0; i < 8; i++) begin
            if (!cap_an[i]) begin
               shadow_d[4*i +: 4] = dec[3:0];
               seen_d[i]          = 1'b1;
            end
         end
      end

      bad_d = bad_q;
      if (err_clr)
         bad_d = 1'b0;
      if (capture && dec[4])
         bad_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_SETTLE;
         prev_q   <= '1;
         cnt_q    <= 16'd0;
         seen_q   <= 8'h00;
         shadow_q <= 32'h0;
         digits_q <= 32'h0;
         valid_q  <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         shadow_q <= shadow_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         bad_q    <= bad_d;
      end
   end

   assign digits_out  = digits_q;
   assign frame_valid = valid_q;
   assign bad_pattern = bad_q;

endmodule
